// File: rtl/stream_reduce_pkg.sv
// Shared definitions for the multi-channel stream reducer: fold modes and
// signed saturation limits used by the lanes when STREAM_REDUCE_SAT_EN is defined.
package stream_reduce_pkg;

   localparam logic [1:0] MODE_ADD = 2'd0;
   localparam logic [1:0] MODE_MAX = 2'd1;
   localparam logic [1:0] MODE_MIN = 2'd2;

   function automatic logic signed [63:0] sat_hi(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_lo(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/stream_reduce_lane.sv
// One reduction lane: loads the first sample of a group, then folds ADD/MAX/MIN.
// Saturating ADD and the sticky clip flag are active when SAT_EN is set.
module stream_reduce_lane
   import stream_reduce_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit SAT_EN = 1'b0
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    start,
   input  logic                    en,
   input  logic [1:0]              mode,
   input  logic signed [WIDTH-1:0] d,
   output logic signed [WIDTH-1:0] acc,
   output logic                    sat
);

   localparam logic signed [WIDTH:0] P_HI = (WIDTH+1)'(sat_hi(WIDTH));
   localparam logic signed [WIDTH:0] P_LO = (WIDTH+1)'(sat_lo(WIDTH));

   logic signed [WIDTH-1:0] r_acc;
   logic                    r_sat;
   logic signed [WIDTH:0]   w_sum;
   logic signed [WIDTH-1:0] w_add;
   logic signed [WIDTH-1:0] w_nxt;
   logic                    w_clip;
   logic                    w_is_add;

   always_comb begin
      // One guard bit is enough to detect overflow of a two-operand add.
      w_sum    = {r_acc[WIDTH-1], r_acc} + {d[WIDTH-1], d};
      w_add    = w_sum[WIDTH-1:0];
      w_clip   = 1'b0;
      w_is_add = (mode != MODE_MAX) && (mode != MODE_MIN);
      if (SAT_EN) begin
         if (w_sum > P_HI) begin
            w_add  = P_HI[WIDTH-1:0];
            w_clip = 1'b1;
         end else if (w_sum < P_LO) begin
            w_add  = P_LO[WIDTH-1:0];
            w_clip = 1'b1;
         end
      end
      case (mode)
         MODE_MAX: w_nxt = (d > r_acc) ? d : r_acc;
         MODE_MIN: w_nxt = (d < r_acc) ? d : r_acc;
         default:  w_nxt = w_add;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_acc <= '0;
         r_sat <= 1'b0;
      end else if (start) begin
         r_acc <= d;
         r_sat <= 1'b0;
      end else if (en) begin
         r_acc <= w_nxt;
         r_sat <= r_sat | (w_clip & w_is_add);
      end
   end

   assign acc = r_acc;
   assign sat = r_sat;

endmodule

// File: rtl/stream_reduce_multi.sv
// Multi-channel streaming reducer: per-lane ADD/MAX/MIN fold over runtime-sized groups.
// Define STREAM_REDUCE_SAT_EN for saturating ADD and the sticky osat output.
module stream_reduce_multi
   import stream_reduce_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int MAX_SIZE = 256,
   parameter int CNT_W    = $clog2(MAX_SIZE + 1)
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      clear,
   input  logic                      ivalid,
   input  logic [CHANNELS*WIDTH-1:0] idata,
   input  logic [CNT_W-1:0]          size,
   input  logic [1:0]                mode,
   output logic                      ovalid,
   output logic [CHANNELS*WIDTH-1:0] odata,
   output logic                      vdata,
`ifdef STREAM_REDUCE_SAT_EN
   output logic                      osat,
`endif
   output logic [CNT_W-1:0]          ocount
);

`ifdef STREAM_REDUCE_SAT_EN
   localparam bit P_SAT_EN = 1'b1;
`else
   localparam bit P_SAT_EN = 1'b0;
`endif

   logic                      r_v1;
   logic [CHANNELS*WIDTH-1:0] r_d1;
   logic [CNT_W-1:0]          r_size1;
   logic [1:0]                r_mode1;
   logic                      r_in_grp;
   logic [CNT_W-1:0]          r_count;
   logic [CNT_W-1:0]          r_cur_size;
   logic [1:0]                r_cur_mode;
   logic                      r_ovalid;
   logic                      r_vdata;

   logic                      w_take;
   logic                      w_start;
   logic [CNT_W-1:0]          w_size_eff;
   logic [CNT_W-1:0]          w_cnt_nxt;
   logic [CNT_W-1:0]          w_size_cmp;
   logic                      w_last;
   logic [1:0]                w_mode_sel;
   logic [CHANNELS*WIDTH-1:0] w_odata;
   logic [CHANNELS-1:0]       w_sat;

   // Stage 1: size/mode travel with the sample so a group samples them alongside its first datum.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_v1    <= 1'b0;
         r_d1    <= '0;
         r_size1 <= '0;
         r_mode1 <= '0;
      end else begin
         r_v1    <= ivalid;
         r_d1    <= idata;
         r_size1 <= size;
         r_mode1 <= mode;
      end
   end

   always_comb begin
      if (r_size1 == '0)
         w_size_eff = CNT_W'(1);
      else if (r_size1 > CNT_W'(MAX_SIZE))
         w_size_eff = CNT_W'(MAX_SIZE);
      else
         w_size_eff = r_size1;
   end

   assign w_take     = r_v1 & ~clear;
   assign w_start    = w_take & ~r_in_grp;
   assign w_cnt_nxt  = r_in_grp ? r_count + CNT_W'(1) : CNT_W'(1);
   assign w_size_cmp = r_in_grp ? r_cur_size : w_size_eff;
   assign w_last     = (w_cnt_nxt == w_size_cmp);
   assign w_mode_sel = r_in_grp ? r_cur_mode : r_mode1;

   // Stage 2: group control; clear wins over the sample sitting in stage 1.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_in_grp   <= 1'b0;
         r_count    <= '0;
         r_cur_size <= '0;
         r_cur_mode <= '0;
         r_ovalid   <= 1'b0;
         r_vdata    <= 1'b0;
      end else begin
         r_ovalid <= w_take;
         r_vdata  <= w_take & w_last;
         if (clear) begin
            r_in_grp <= 1'b0;
            r_count  <= '0;
         end else if (r_v1) begin
            r_count  <= w_cnt_nxt;
            r_in_grp <= ~w_last;
            if (w_start) begin
               r_cur_size <= w_size_eff;
               r_cur_mode <= r_mode1;
            end
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      stream_reduce_lane #(
         .WIDTH  (WIDTH),
         .SAT_EN (P_SAT_EN)
      ) u_lane (
         .CLK   (CLK),
         .RST_N (RST_N),
         .start (w_start),
         .en    (w_take),
         .mode  (w_mode_sel),
         .d     (r_d1[g*WIDTH +: WIDTH]),
         .acc   (w_odata[g*WIDTH +: WIDTH]),
         .sat   (w_sat[g])
      );
   end

   assign ovalid = r_ovalid;
   assign vdata  = r_vdata;
   assign ocount = r_count;
   assign odata  = w_odata;

`ifdef STREAM_REDUCE_SAT_EN
   assign osat = |w_sat;
`else
   logic w_sat_unused;
   assign w_sat_unused = |w_sat;
`endif

endmodule

// File: tb/tb_stream_reduce_multi.sv
// Randomized self-checking bench for stream_reduce_multi against a group-level reference fold.
// Honors STREAM_REDUCE_SAT_EN the same way the design does.
module tb_stream_reduce_multi;

   localparam int W  = 32;
   localparam int CH = 4;
   localparam int MS = 256;
   localparam int CW = $clog2(MS + 1);
   localparam int DW = CH * W;
   localparam longint HI = (64'sd1 <<< (W - 1)) - 1;
   localparam longint LO = -(64'sd1 <<< (W - 1));

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          clear = 1'b0;
   logic          ivalid = 1'b0;
   logic [DW-1:0] idata = '0;
   logic [CW-1:0] size = '0;
   logic [1:0]    mode = '0;
   logic          ovalid;
   logic          vdata;
   logic [DW-1:0] odata;
   logic [CW-1:0] ocount;
`ifdef STREAM_REDUCE_SAT_EN
   logic          osat;
`endif

   int checks = 0;
   int failures = 0;
   int vd_log[$];
   int oc_log[$];

   stream_reduce_multi #(.WIDTH(W), .CHANNELS(CH), .MAX_SIZE(MS)) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .clear  (clear),
      .ivalid (ivalid),
      .idata  (idata),
      .size   (size),
      .mode   (mode),
      .ovalid (ovalid),
      .odata  (odata),
      .vdata  (vdata),
`ifdef STREAM_REDUCE_SAT_EN
      .osat   (osat),
`endif
      .ocount (ocount)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: the current group is a list of samples; the result is a fold over it.
   logic          p_v;
   logic [DW-1:0] p_d;
   logic [CW-1:0] p_size;
   logic [1:0]    p_mode;
   bit            in_grp;
   int            gsize;
   logic [1:0]    gmode;
   logic [DW-1:0] grp_q[$];
   logic          e_v, e_vd, e_sat;
   logic [DW-1:0] e_od;
   int            e_cnt;

   function automatic void fold(output logic [DW-1:0] od, output logic st);
      st = 1'b0;
      od = '0;
      for (int c = 0; c < CH; c++) begin
         longint acc;
         acc = 0;
         for (int k = 0; k < grp_q.size(); k++) begin
            logic signed [W-1:0] x;
            longint v;
            x = grp_q[k][c*W +: W];
            v = longint'(x);
            if (k == 0) acc = v;
            else if (gmode == 2'd1) acc = (v > acc) ? v : acc;
            else if (gmode == 2'd2) acc = (v < acc) ? v : acc;
            else begin
               acc = acc + v;
`ifdef STREAM_REDUCE_SAT_EN
               if (acc > HI) begin acc = HI; st = 1'b1; end
               else if (acc < LO) begin acc = LO; st = 1'b1; end
`else
               acc = longint'($signed(acc[W-1:0]));
`endif
            end
         end
         od[c*W +: W] = acc[W-1:0];
      end
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p_v = 1'b0; p_d = '0; p_size = '0; p_mode = '0;
         in_grp = 0; gsize = 0; gmode = '0; grp_q.delete();
         e_v = 1'b0; e_vd = 1'b0; e_sat = 1'b0; e_od = '0; e_cnt = 0;
      end else begin
         e_v = 1'b0;
         e_vd = 1'b0;
         if (clear) begin
            in_grp = 0;
            e_cnt = 0;
         end else if (p_v) begin
            if (!in_grp) begin
               grp_q.delete();
               gsize = (p_size == 0) ? 1 : ((int'(p_size) > MS) ? MS : int'(p_size));
               gmode = p_mode;
               in_grp = 1;
            end
            grp_q.push_back(p_d);
            e_cnt = grp_q.size();
            fold(e_od, e_sat);
            e_v = 1'b1;
            e_vd = (e_cnt == gsize);
            if (e_vd) in_grp = 0;
         end
         p_v = ivalid; p_d = idata; p_size = size; p_mode = mode;
      end
   end

   always @(negedge CLK) begin
      if (RST_N) begin
         chk("ovalid", DW'(ovalid), DW'(e_v));
         chk("vdata", DW'(vdata), DW'(e_vd));
         chk("odata", odata, e_od);
         chk("ocount", DW'(ocount), DW'(e_cnt[CW-1:0]));
`ifdef STREAM_REDUCE_SAT_EN
         chk("osat", DW'(osat), DW'(e_sat));
`endif
         if (ovalid) begin
            oc_log.push_back(int'(ocount));
            if (vdata) vd_log.push_back(int'($signed(odata[W-1:0])));
         end
      end
   end

   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic c);
      @(posedge CLK);
      #1;
      ivalid = v;
      idata  = d;
      clear  = c;
   endtask

   function automatic logic [DW-1:0] rnd();
      logic [DW-1:0] r;
      for (int c = 0; c < CH; c++) r[c*W +: W] = $urandom;
      return r;
   endfunction

   function automatic logic [DW-1:0] with_l0(input int l0);
      logic [DW-1:0] r;
      r = rnd();
      r[W-1:0] = l0;
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, rnd(), 1'b0);
   endtask

   task automatic clr_logs();
      vd_log.delete();
      oc_log.delete();
   endtask

   initial begin
      int t1_exp[4] = '{120, 376, 632, 888};
      int t2_seq[8] = '{3, -7, 9, 2, 1, 1, 1, 1};
      logic [DW-1:0] d;

      repeat (3) @(posedge CLK);
      #1;
      chk("rst_ovalid", DW'(ovalid), '0);
      chk("rst_odata", odata, '0);
      chk("rst_vdata", DW'(vdata), '0);
      chk("rst_ocount", DW'(ocount), '0);
      RST_N = 1'b1;

      // Test 1: ADD over groups of 16, lane i = n*(i+1)
      size = CW'(16); mode = 2'd0; clr_logs();
      for (int n = 0; n < 64; n++) begin
         for (int c = 0; c < CH; c++) d[c*W +: W] = n * (c + 1);
         cyc(1'b1, d, 1'b0);
      end
      idle(4);
      chk("t1_groups", DW'(vd_log.size()), DW'(4));
      for (int g = 0; g < 4; g++) chk("t1_lane0", DW'(vd_log[g]), DW'(t1_exp[g]));

      // Test 2: MAX then MIN, size 4
      for (int m = 1; m <= 2; m++) begin
         size = CW'(4); mode = 2'(m); clr_logs();
         for (int k = 0; k < 8; k++) cyc(1'b1, with_l0(t2_seq[k]), 1'b0);
         idle(4);
         chk("t2_groups", DW'(vd_log.size()), DW'(2));
         chk("t2_first", DW'(vd_log[0]), DW'((m == 1) ? 9 : -7));
         chk("t2_second", DW'(vd_log[1]), DW'(1));
      end

      // Test 3: size 0, then oversize clipped to MS, mid-group size change deferred
      size = '0; mode = 2'd0; clr_logs();
      for (int k = 0; k < 3; k++) cyc(1'b1, rnd(), 1'b0);
      idle(4);
      chk("t3_size0", DW'(vd_log.size()), DW'(3));
      size = CW'(MS + 5); clr_logs();
      for (int k = 0; k < MS + 5; k++) begin
         cyc(1'b1, rnd(), 1'b0);
         if (k == 9) size = CW'(5);
      end
      idle(4);
      chk("t3_groups", DW'(vd_log.size()), DW'(2));
      chk("t3_max_cnt", DW'(oc_log[MS-1]), DW'(MS));
      chk("t3_next_cnt", DW'(oc_log[MS+4]), DW'(5));

      // Test 4: alternating valid, size 3
      size = CW'(3); mode = 2'd0; clr_logs();
      for (int k = 0; k < 8; k++) cyc(k % 2 == 0, rnd(), 1'b0);
      idle(4);
      chk("t4_n", DW'(oc_log.size()), DW'(4));
      for (int k = 0; k < 4; k++) chk("t4_ocount", DW'(oc_log[k]), DW'((k == 3) ? 1 : k + 1));
      chk("t4_vdata", DW'(vd_log.size()), DW'(1));

      // Test 5: clear after 5 accepted samples drops the 6th in flight
      cyc(1'b0, rnd(), 1'b1);
      size = CW'(8); mode = 2'd0; clr_logs();
      for (int k = 0; k < 6; k++) cyc(1'b1, with_l0(100 + k), 1'b0);
      cyc(1'b0, rnd(), 1'b1);
      for (int k = 0; k < 8; k++) cyc(1'b1, with_l0(k + 1), 1'b0);
      idle(4);
      chk("t5_ovalids", DW'(oc_log.size()), DW'(13));
      chk("t5_groups", DW'(vd_log.size()), DW'(1));
      chk("t5_sum", DW'(vd_log[0]), DW'(36));

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         size = CW'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12));
         mode = 2'($urandom_range(0, 3));
         cyc($urandom_range(0, 9) < 7, rnd(), $urandom_range(0, 99) < 3);
      end
      cyc(1'b0, rnd(), 1'b1);
      idle(3);

      // Test 6: asynchronous reset mid-group
      size = CW'(10); mode = 2'd0;
      for (int k = 0; k < 4; k++) cyc(1'b1, with_l0(1000), 1'b0);
      @(posedge CLK);
      #3;
      RST_N = 1'b0;
      ivalid = 1'b0;
      #1;
      chk("arst_ovalid", DW'(ovalid), '0);
      chk("arst_odata", odata, '0);
      chk("arst_vdata", DW'(vdata), '0);
      chk("arst_ocount", DW'(ocount), '0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;

      // Overflowing ADD: saturate or wrap depending on build
      size = CW'(2); mode = 2'd0; clr_logs();
      d = '0; d[W-1:0] = 32'h7FFF_FFF0;
      cyc(1'b1, d, 1'b0);
      d = '0; d[W-1:0] = 32'h0000_0020;
      cyc(1'b1, d, 1'b0);
      idle(4);
      chk("t6_groups", DW'(vd_log.size()), DW'(1));
`ifdef STREAM_REDUCE_SAT_EN
      chk("t6_sat_val", DW'(vd_log[0]), DW'(int'(32'h7FFF_FFFF)));
      chk("t6_osat", DW'(osat), DW'(1));
`else
      chk("t6_wrap_val", DW'(vd_log[0]), DW'(int'(32'h8000_0010)));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
